// File: rtl/uf_stage_controller_pkg.sv
// Shared stage encodings for the union-find decoder array. The processing
// units decode the same global_stage values, so these must never be reordered.
package uf_stage_controller_pkg;

    localparam int STAGE_WIDTH = 3;

    typedef enum logic [STAGE_WIDTH-1:0] {
        STAGE_IDLE                = 3'd0,
        STAGE_MEASUREMENT_LOADING = 3'd1,
        STAGE_GROW                = 3'd2,
        STAGE_MERGE               = 3'd3,
        STAGE_PEELING             = 3'd4,
        STAGE_RESULT_VALID        = 3'd5
    } stage_e;

    // Width of a counter that must hold values 0..max_value (at least 1 bit).
    function automatic int cnt_width(input int max_value);
        int w;
        w = $clog2(max_value + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/uf_stage_controller_or_reduce.sv
// Two-level OR reduction of the per-PU status bits. Purely combinational:
// the controller's MERGE dwell assumes zero added latency from this tree.
module or_reduce_pipeline_tree #(
    parameter int WIDTH = 300,
    parameter int CHUNK = 16
) (
    input  logic [WIDTH-1:0] i_bits,
    output logic             o_any
);

    localparam int N_CHUNK = (WIDTH + CHUNK - 1) / CHUNK;

    logic [N_CHUNK*CHUNK-1:0] w_padded;
    logic [N_CHUNK-1:0]       w_partial;

    // Zero-pad the input to a whole number of chunks.
    always_comb begin
        w_padded              = '0;
        w_padded[WIDTH-1:0]   = i_bits;
    end

    genvar g;
    generate
        for (g = 0; g < N_CHUNK; g = g + 1) begin : g_chunk
            assign w_partial[g] = |w_padded[g*CHUNK +: CHUNK];
        end
    endgenerate

    assign o_any = |w_partial;

endmodule

// File: rtl/uf_stage_controller.sv
// Central sequencer of the union-find decoder array. Broadcasts the stage to
// all PUs, watches the reduced busy/odd flags for merge convergence, and hands
// back one result (grow count + error flag) per accepted syndrome round.
module uf_stage_controller
    import uf_stage_controller_pkg::*;
#(
    parameter int PU_COUNT         = 300,
    parameter int ITER_WIDTH       = 8,
    parameter int MAX_GROW_ITER    = 64,
    parameter int MERGE_MIN_CYCLES = 3,
    parameter int MAX_MERGE_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   meas_valid,
    output logic                   meas_ready,
    input  logic [PU_COUNT-1:0]    pu_busy,
    input  logic [PU_COUNT-1:0]    pu_odd,
    output logic [STAGE_WIDTH-1:0] global_stage,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [ITER_WIDTH-1:0]  grow_iterations,
    output logic                   decode_error
);

    localparam int MW = cnt_width(MAX_MERGE_CYCLES);
    localparam logic [MW-1:0]         C_MERGE_EXIT  = MW'(MERGE_MIN_CYCLES - 1);
    localparam logic [MW-1:0]         C_MERGE_LIMIT = MW'(MAX_MERGE_CYCLES);
    localparam logic [MW-1:0]         C_MERGE_SAT   = '1;
    localparam logic [ITER_WIDTH-1:0] C_GROW_LIMIT  = ITER_WIDTH'(MAX_GROW_ITER);
    localparam logic [ITER_WIDTH-1:0] C_ITER_SAT    = '1;

    stage_e                r_state;
    stage_e                w_next_state;
    logic                  r_phase;
    logic [MW-1:0]         r_merge_cnt;
    logic [ITER_WIDTH-1:0] r_grow_iter;
    logic                  r_error;
    logic                  r_meas_ready;
    logic                  r_result_valid;
    logic                  w_any_busy;
    logic                  w_any_odd;
    logic                  w_accept;
    logic                  w_set_error;
    logic                  w_grow_entry;

    or_reduce_pipeline_tree #(.WIDTH(PU_COUNT)) u_busy_reduce (
        .i_bits (pu_busy),
        .o_any  (w_any_busy)
    );

    or_reduce_pipeline_tree #(.WIDTH(PU_COUNT)) u_odd_reduce (
        .i_bits (pu_odd),
        .o_any  (w_any_odd)
    );

    assign w_accept     = (r_state == STAGE_IDLE) && meas_valid && r_meas_ready;
    assign w_grow_entry = (r_state != STAGE_GROW) && (w_next_state == STAGE_GROW);

    // Next-state logic; also flags the MERGE exits that abort with an error.
    always_comb begin
        w_next_state = r_state;
        w_set_error  = 1'b0;
        case (r_state)
            STAGE_IDLE: begin
                if (w_accept) begin
                    w_next_state = STAGE_MEASUREMENT_LOADING;
                end else begin
                    w_next_state = STAGE_IDLE;
                end
            end
            STAGE_MEASUREMENT_LOADING: begin
                if (r_phase) begin
                    w_next_state = STAGE_MERGE;
                end else begin
                    w_next_state = STAGE_MEASUREMENT_LOADING;
                end
            end
            STAGE_GROW: begin
                if (r_phase) begin
                    w_next_state = STAGE_MERGE;
                end else begin
                    w_next_state = STAGE_GROW;
                end
            end
            STAGE_MERGE: begin
                // Convergence is tested first so it wins over the timeout.
                if ((r_merge_cnt >= C_MERGE_EXIT) && !w_any_busy) begin
                    if (w_any_odd) begin
                        if (r_grow_iter >= C_GROW_LIMIT) begin
                            w_next_state = STAGE_PEELING;
                            w_set_error  = 1'b1;
                        end else begin
                            w_next_state = STAGE_GROW;
                        end
                    end else begin
                        w_next_state = STAGE_PEELING;
                    end
                end else if (r_merge_cnt >= C_MERGE_LIMIT) begin
                    w_next_state = STAGE_PEELING;
                    w_set_error  = 1'b1;
                end else begin
                    w_next_state = STAGE_MERGE;
                end
            end
            STAGE_PEELING: begin
                w_next_state = STAGE_RESULT_VALID;
            end
            STAGE_RESULT_VALID: begin
                if (result_ready) begin
                    w_next_state = STAGE_IDLE;
                end else begin
                    w_next_state = STAGE_RESULT_VALID;
                end
            end
            default: begin
                w_next_state = STAGE_IDLE;
            end
        endcase
    end

    // State register plus the handshake flags decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= STAGE_IDLE;
            r_meas_ready   <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_meas_ready   <= (w_next_state == STAGE_IDLE);
            r_result_valid <= (w_next_state == STAGE_RESULT_VALID);
        end
    end

    // Phase bit: 0 in the first cycle of a state, 1 afterwards (2-cycle stages).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= 1'b0;
        end else if (w_next_state != r_state) begin
            r_phase <= 1'b0;
        end else begin
            r_phase <= 1'b1;
        end
    end

    // MERGE dwell counter: zero on entry, counts while in MERGE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_merge_cnt <= '0;
        end else if (r_state != STAGE_MERGE) begin
            r_merge_cnt <= '0;
        end else if (r_merge_cnt != C_MERGE_SAT) begin
            r_merge_cnt <= r_merge_cnt + MW'(1);
        end else begin
            r_merge_cnt <= r_merge_cnt;
        end
    end

    // Grow-iteration count: cleared on accept, bumped on every GROW entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grow_iter <= '0;
        end else if (w_accept) begin
            r_grow_iter <= '0;
        end else if (w_grow_entry && (r_grow_iter != C_ITER_SAT)) begin
            r_grow_iter <= r_grow_iter + ITER_WIDTH'(1);
        end else begin
            r_grow_iter <= r_grow_iter;
        end
    end

    // Sticky per-round error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if (w_accept) begin
            r_error <= 1'b0;
        end else if (w_set_error) begin
            r_error <= 1'b1;
        end else begin
            r_error <= r_error;
        end
    end

    assign global_stage    = r_state;
    assign meas_ready      = r_meas_ready;
    assign result_valid    = r_result_valid;
    assign grow_iterations = r_grow_iter;
    assign decode_error    = r_error;

endmodule

// File: tb/tb_uf_stage_controller.sv
// Self-checking bench for uf_stage_controller. A round is described as a list
// of MERGE visits (how long busy stays high, whether odd defects remain); the
// reference model expands that into the expected per-cycle stage timeline,
// iteration count and error flag, and the same timeline drives the PU inputs.
module tb_uf_stage_controller;

    localparam int PU_COUNT = 300;
    localparam int MAXG     = 4;
    localparam int MMIN     = 3;
    localparam int MAXM     = 10;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_GROW  = 3'd2;
    localparam logic [2:0] S_MERGE = 3'd3;
    localparam logic [2:0] S_PEEL  = 3'd4;
    localparam logic [2:0] S_RES   = 3'd5;

    logic                clk;
    logic                reset;
    logic                meas_valid;
    logic                meas_ready;
    logic [PU_COUNT-1:0] pu_busy;
    logic [PU_COUNT-1:0] pu_odd;
    logic [2:0]          global_stage;
    logic                result_valid;
    logic                result_ready;
    logic [7:0]          grow_iterations;
    logic                decode_error;

    int errors;
    int checks;

    // Reference-model outputs for the round being run.
    logic [2:0]          exp_stage[$];
    logic [7:0]          exp_iter[$];
    logic                exp_errq[$];
    logic [PU_COUNT-1:0] q_busy[$];
    logic [PU_COUNT-1:0] q_odd[$];
    int                  vis_busy[8];
    bit                  vis_odd[8];
    int                  exp_grows;
    bit                  exp_err;
    int                  second_grow_idx;

    uf_stage_controller #(
        .PU_COUNT         (PU_COUNT),
        .ITER_WIDTH       (8),
        .MAX_GROW_ITER    (MAXG),
        .MERGE_MIN_CYCLES (MMIN),
        .MAX_MERGE_CYCLES (MAXM)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .meas_valid      (meas_valid),
        .meas_ready      (meas_ready),
        .pu_busy         (pu_busy),
        .pu_odd          (pu_odd),
        .global_stage    (global_stage),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .grow_iterations (grow_iterations),
        .decode_error    (decode_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PU_COUNT-1:0] rand_vec(input bit en);
        logic [PU_COUNT-1:0] v;
        v = '0;
        if (en) v[$urandom_range(0, PU_COUNT-1)] = 1'b1;
        return v;
    endfunction

    function automatic void push(input logic [2:0] s, input logic [PU_COUNT-1:0] b,
                                 input logic [PU_COUNT-1:0] o, input int it, input bit e);
        exp_stage.push_back(s);
        q_busy.push_back(b);
        q_odd.push_back(o);
        exp_iter.push_back(8'(it));
        exp_errq.push_back(e);
    endfunction

    function automatic void clear_visits();
        for (int k = 0; k < 8; k++) begin
            vis_busy[k] = 0;
            vis_odd[k]  = 1'b0;
        end
    endfunction

    // Expand the visit list into the expected timeline from the stage rules.
    function automatic void build_expected();
        int  k;
        int  b;
        int  dwell;
        bit  o;
        bit  done;
        logic [PU_COUNT-1:0] ov;
        exp_stage.delete(); exp_iter.delete(); exp_errq.delete();
        q_busy.delete(); q_odd.delete();
        exp_grows = 0; exp_err = 1'b0; second_grow_idx = -1;
        push(S_LOAD, rand_vec($urandom_range(0, 1)), rand_vec($urandom_range(0, 1)), 0, 1'b0);
        push(S_LOAD, rand_vec($urandom_range(0, 1)), rand_vec($urandom_range(0, 1)), 0, 1'b0);
        k = 0; done = 1'b0;
        while (!done) begin
            b = (k < 8) ? vis_busy[k] : 0;
            o = (k < 8) ? vis_odd[k] : 1'b0;
            ov = rand_vec(o);
            // Busy is high for the first b MERGE cycles; exit needs busy low
            // and at least MMIN cycles, or the timeout at count MAXM.
            if (b > MAXM) dwell = MAXM + 1;
            else          dwell = (b + 1 > MMIN) ? b + 1 : MMIN;
            for (int c = 0; c < dwell; c++)
                push(S_MERGE, rand_vec(c < b), ov, exp_grows, 1'b0);
            if (b > MAXM) begin
                exp_err = 1'b1; done = 1'b1;
            end else if (o && exp_grows == MAXG) begin
                exp_err = 1'b1; done = 1'b1;
            end else if (o) begin
                exp_grows++;
                if (exp_grows == 2) second_grow_idx = exp_stage.size();
                push(S_GROW, rand_vec($urandom_range(0, 1)), rand_vec($urandom_range(0, 1)), exp_grows, 1'b0);
                push(S_GROW, rand_vec($urandom_range(0, 1)), rand_vec($urandom_range(0, 1)), exp_grows, 1'b0);
                k++;
            end else begin
                done = 1'b1;
            end
        end
        push(S_PEEL, rand_vec($urandom_range(0, 1)), rand_vec($urandom_range(0, 1)), exp_grows, exp_err);
    endfunction

    // Accept one round, follow the timeline, then hold RESULT for 'hold' cycles.
    task automatic run_round(input string tag, input int hold, input int abort_at);
        int n;
        build_expected();
        n = 0;
        while (meas_ready !== 1'b1 && n < 20) begin
            @(posedge clk); @(negedge clk); n++;
        end
        checks++;
        if (meas_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept_wait: meas_ready=%b required 1", tag, meas_ready);
            return;
        end
        result_ready = (hold == 0);
        meas_valid   = 1'b1;
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < exp_stage.size(); i++) begin
            checks++;
            if (global_stage !== exp_stage[i] || grow_iterations !== exp_iter[i] ||
                decode_error !== exp_errq[i]) begin
                errors++;
                $display("FAIL %s cycle%0d: stage=%0d iter=%0d err=%b required stage=%0d iter=%0d err=%b",
                         tag, i, global_stage, grow_iterations, decode_error,
                         exp_stage[i], exp_iter[i], exp_errq[i]);
            end
            checks++;
            if (result_valid !== 1'b0 || meas_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hs_cycle%0d: result_valid=%b meas_ready=%b required 0 0",
                         tag, i, result_valid, meas_ready);
            end
            if (i == abort_at) begin
                reset = 1'b1; meas_valid = 1'b0;
                @(posedge clk); @(negedge clk);
                checks++;
                if (global_stage !== S_IDLE || result_valid !== 1'b0 || grow_iterations !== 8'd0 ||
                    decode_error !== 1'b0 || meas_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s abort: stage=%0d rv=%b iter=%0d err=%b mr=%b required 0 0 0 0 0",
                             tag, global_stage, result_valid, grow_iterations, decode_error, meas_ready);
                end
                reset = 1'b0; pu_busy = '0; pu_odd = '0; result_ready = 1'b0;
                return;
            end
            pu_busy    = q_busy[i];
            pu_odd     = q_odd[i];
            meas_valid = 1'($urandom_range(0, 1));
            @(posedge clk); @(negedge clk);
        end
        for (int h = 0; h <= hold; h++) begin
            checks++;
            if (global_stage !== S_RES || result_valid !== 1'b1 || meas_ready !== 1'b0 ||
                grow_iterations !== 8'(exp_grows) || decode_error !== exp_err) begin
                errors++;
                $display("FAIL %s result%0d: stage=%0d rv=%b mr=%b iter=%0d err=%b required 5 1 0 %0d %b",
                         tag, h, global_stage, result_valid, meas_ready, grow_iterations,
                         decode_error, exp_grows, exp_err);
            end
            result_ready = (h == hold);
            meas_valid   = 1'($urandom_range(0, 1));
            pu_busy      = rand_vec($urandom_range(0, 1));
            pu_odd       = rand_vec($urandom_range(0, 1));
            @(posedge clk); @(negedge clk);
        end
        checks++;
        if (global_stage !== S_IDLE || result_valid !== 1'b0 || meas_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s return_idle: stage=%0d rv=%b mr=%b required 0 0 1",
                     tag, global_stage, result_valid, meas_ready);
        end
        result_ready = 1'b0; meas_valid = 1'b0; pu_busy = '0; pu_odd = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; meas_valid = 1'b0; result_ready = 1'b0; pu_busy = '0; pu_odd = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (global_stage !== S_IDLE || meas_ready !== 1'b0 || result_valid !== 1'b0 ||
            grow_iterations !== 8'd0 || decode_error !== 1'b0) begin
            errors++;
            $display("FAIL reset: stage=%0d mr=%b rv=%b iter=%0d err=%b required 0 0 0 0 0",
                     global_stage, meas_ready, result_valid, grow_iterations, decode_error);
        end
        reset = 1'b0;
    endtask

    task automatic test_no_defects();
        clear_visits();
        run_round("no_defects", 0, -1);
    endtask

    task automatic test_two_grows();
        clear_visits();
        vis_busy[0] = 2; vis_odd[0] = 1'b1;
        vis_busy[1] = 4; vis_odd[1] = 1'b1;
        vis_busy[2] = 2; vis_odd[2] = 1'b0;
        run_round("two_grows", 1, -1);
    endtask

    task automatic test_grow_limit();
        clear_visits();
        for (int k = 0; k < 8; k++) vis_odd[k] = 1'b1;
        run_round("grow_limit", 2, -1);
    endtask

    task automatic test_merge_timeout();
        clear_visits();
        vis_busy[0] = MAXM + 1;
        run_round("merge_timeout", 0, -1);
        clear_visits();
        vis_busy[0] = MAXM;
        run_round("merge_edge", 0, -1);
    endtask

    task automatic test_result_hold();
        clear_visits();
        vis_busy[0] = 1; vis_odd[0] = 1'b1;
        run_round("result_hold", 5, -1);
    endtask

    task automatic test_mid_round_reset();
        clear_visits();
        vis_odd[0] = 1'b1; vis_odd[1] = 1'b1; vis_busy[1] = 3;
        build_expected();
        run_round("mid_reset", 0, second_grow_idx + 1);
        clear_visits();
        run_round("after_reset", 0, -1);
    endtask

    task automatic test_back_to_back();
        clear_visits();
        run_round("b2b_first", 0, -1);
        vis_odd[0] = 1'b1;
        run_round("b2b_second", 0, -1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 10; r++) begin
            clear_visits();
            for (int k = 0; k < 8; k++) begin
                vis_busy[k] = $urandom_range(0, 12);
                vis_odd[k]  = ($urandom_range(0, 2) != 0);
            end
            run_round($sformatf("random%0d", r), $urandom_range(0, 3), -1);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_no_defects();
        test_two_grows();
        test_grow_limit();
        test_merge_timeout();
        test_result_hold();
        test_mid_round_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
